pic16_seq: RTL



---
 rtl/pic16_seq_pkg.sv | 40 ++++
 rtl/pic16_idec.sv | 66 ++++++
 rtl/pic16_seq.sv | 75 +++++++
 3 files changed

// File: rtl/pic16_seq_pkg.sv
// pic16_seq_pkg: shared state encodings, ALU op codes and decode record for the PIC16 sequencer.
package pic16_seq_pkg;
  localparam int FADR_W = 7;
  localparam int PC_W = 11;
  typedef enum logic [2:0] {S_IDLE, S_Q1, S_Q2, S_Q3, S_Q4} state_t;
  typedef enum logic [1:0] {SK_NONE, SK_Z, SK_NZ} skip_t;
  localparam logic [4:0] INOP = 5'd0;
  localparam logic [4:0] IADD = 5'd1;
  localparam logic [4:0] ISUB = 5'd2;
  localparam logic [4:0] IAND = 5'd3;
  localparam logic [4:0] IIOR = 5'd4;
  localparam logic [4:0] IXOR = 5'd5;
  localparam logic [4:0] ICOM = 5'd6;
  localparam logic [4:0] IDEC = 5'd7;
  localparam logic [4:0] IINC = 5'd8;
  localparam logic [4:0] IPSF = 5'd9;
  localparam logic [4:0] IPSW = 5'd10;
  localparam logic [4:0] IRLF = 5'd11;
  localparam logic [4:0] IRRF = 5'd12;
  localparam logic [4:0] ISWP = 5'd13;
  localparam logic [4:0] ICLR = 5'd14;
  localparam logic [4:0] IBCF = 5'd15;
  localparam logic [4:0] IBSF = 5'd16;
  localparam logic [4:0] IBTF = 5'd17;
  typedef struct packed {
    logic [4:0]  cb;
    logic [2:0]  b;
    logic [7:0]  k;
    logic [6:0]  fadr;
    logic        lsel;
    logic        we;
    logic        fwe;
    logic        ze;
    logic        ce;
    logic        dce;
    logic        jmp;
    logic [10:0] jtgt;
    skip_t       skip;
  } dec_t;
endpackage

// File: rtl/pic16_idec.sv
// pic16_idec: combinational decode of a latched 14-bit instruction into ALU controls, enables and skip type.
module pic16_idec
  import pic16_seq_pkg::*;
(
  input  logic [13:0] ir,
  output dec_t        dec
);
  always_comb begin
    dec = '0;
    case (ir[13:12])
      2'b00: begin
        dec.fadr = ir[6:0];
        dec.we = ~ir[7];
        dec.fwe = ir[7];
        case (ir[11:8])
          4'h7: begin dec.cb = IADD; {dec.ze, dec.ce, dec.dce} = 3'b111; end
          4'h2: begin dec.cb = ISUB; {dec.ze, dec.ce, dec.dce} = 3'b111; end
          4'h5: begin dec.cb = IAND; dec.ze = 1'b1; end
          4'h4: begin dec.cb = IIOR; dec.ze = 1'b1; end
          4'h6: begin dec.cb = IXOR; dec.ze = 1'b1; end
          4'h9: begin dec.cb = ICOM; dec.ze = 1'b1; end
          4'h3: begin dec.cb = IDEC; dec.ze = 1'b1; end
          4'hA: begin dec.cb = IINC; dec.ze = 1'b1; end
          4'hB: begin dec.cb = IDEC; dec.skip = SK_Z; end
          4'hF: begin dec.cb = IINC; dec.skip = SK_Z; end
          4'h8: begin dec.cb = IPSF; dec.ze = 1'b1; end
          4'hD: begin dec.cb = IRLF; dec.ce = 1'b1; end
          4'hC: begin dec.cb = IRRF; dec.ce = 1'b1; end
          4'hE: dec.cb = ISWP;
          4'h1: begin dec.cb = ICLR; dec.ze = 1'b1; end
          default: begin
            dec.cb = ir[7] ? IPSW : INOP;
            dec.we = 1'b0;
            dec.jmp = ir == 14'h0008;
          end
        endcase
      end
      2'b01: begin
        dec.fadr = ir[6:0];
        dec.b = ir[9:7];
        dec.cb = ir[11] ? IBTF : (ir[10] ? IBSF : IBCF);
        dec.fwe = ~ir[11];
        dec.skip = ir[11] ? (ir[10] ? SK_NZ : SK_Z) : SK_NONE;
      end
      2'b10: begin
        dec.jmp = 1'b1;
        dec.jtgt = ir[10:0];
      end
      default: begin
        dec.lsel = 1'b1;
        dec.k = ir[7:0];
        dec.we = 1'b1;
        casez (ir[11:8])
          4'b00??: dec.cb = IPSF;
          4'b01??: begin dec.cb = IPSF; dec.jmp = 1'b1; end
          4'b1000: begin dec.cb = IIOR; dec.ze = 1'b1; end
          4'b1001: begin dec.cb = IAND; dec.ze = 1'b1; end
          4'b1010: begin dec.cb = IXOR; dec.ze = 1'b1; end
          4'b110?: begin dec.cb = ISUB; {dec.ze, dec.ce, dec.dce} = 3'b111; end
          4'b111?: begin dec.cb = IADD; {dec.ze, dec.ce, dec.dce} = 3'b111; end
          default: dec = '0;
        endcase
      end
    endcase
  end
endmodule

// File: rtl/pic16_seq.sv
// pic16_seq: four-phase Q1-Q4 instruction sequencer with fetch handshake, Q4 enables and skip squashing.
module pic16_seq
  import pic16_seq_pkg::*;
#(
  parameter int FADR_W = 7,
  parameter int PC_W = 11
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [13:0]       IR,
  input  logic              IR_VLD,
  output logic              IR_ACK,
  output logic [4:0]        CB,
  output logic [2:0]        B,
  output logic              WE,
  output logic              FWE,
  output logic [FADR_W-1:0] FADR,
  output logic              LSEL,
  output logic [7:0]        K,
  output logic              ZE,
  output logic              CE,
  output logic              DCE,
  input  logic              ALU_Z,
  output logic              JMP,
  output logic [PC_W-1:0]   JTGT,
  output logic [1:0]        PHASE
);
  state_t state, nxt;
  logic [13:0] ir_r;
  logic sq, q4, fire;
  dec_t dec;
  pic16_idec u_idec (.ir(ir_r), .dec(dec));
  // Reset gates the Q4 strobes combinationally so an in-flight writeback never escapes.
  assign q4 = state == S_Q4;
  assign fire = q4 & ~sq & ~RST;
  assign IR_ACK = (state == S_IDLE || q4) & IR_VLD & ~RST;
  assign {WE, FWE, ZE, CE, DCE, JMP} = {6{fire}} & {dec.we, dec.fwe, dec.ze, dec.ce, dec.dce, dec.jmp};
  assign PHASE = state == S_Q2 ? 2'd1 : state == S_Q3 ? 2'd2 : q4 ? 2'd3 : 2'd0;
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE: nxt = IR_VLD ? S_Q1 : S_IDLE;
      S_Q1:   nxt = S_Q2;
      S_Q2:   nxt = S_Q3;
      S_Q3:   nxt = S_Q4;
      S_Q4:   nxt = IR_VLD ? S_Q1 : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      ir_r <= '0;
      sq <= 1'b0;
      CB <= '0;
      B <= '0;
      K <= '0;
      FADR <= '0;
      LSEL <= 1'b0;
      JTGT <= '0;
    end else begin
      state <= nxt;
      if (IR_ACK) ir_r <= IR;
      if (q4) sq <= ~sq & (dec.jmp | ((dec.skip == SK_Z) & ALU_Z) | ((dec.skip == SK_NZ) & ~ALU_Z));
      if (state == S_Q1) begin
        CB <= dec.cb;
        B <= dec.b;
        K <= dec.k;
        FADR <= FADR_W'(dec.fadr);
        LSEL <= dec.lsel;
        JTGT <= PC_W'(dec.jtgt);
      end
    end
  end
endmodule
